// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES wait states and a word-addressed RAM.
// Optional per-byte store strobes (i_req_be) are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]  i_req_be,
`endif
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic [15:0] o_test_value
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [15:0] r_test_value;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic [AW-1:0] w_idx;
   logic          w_err;
   logic [31:0]   w_old;
   logic [31:0]   w_wword;

   assign w_idx = r_addr[AW+1:2];
   // Power-of-2 depth: any set bit above the index field means out of range.
   assign w_err = (r_addr[1:0] != 2'b00) | (r_addr[31:AW+2] != '0);
   assign w_old = r_mem[w_idx];

`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0] r_be;

   always_comb begin
      w_wword = w_old;
      for (int unsigned b = 0; b < 4; b++) begin
         if (r_be[b]) w_wword[8*b +: 8] = r_wdata[8*b +: 8];
      end
   end
`else
   assign w_wword = r_wdata;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
`ifdef DMEM_BYTE_STROBE_EN
         r_be         <= '0;
`endif
         r_rdata      <= '0;
         r_err        <= 1'b0;
         r_test_value <= '0;
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[AW'(i)] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_we    <= i_req_we;
                  r_addr  <= i_req_addr;
                  r_wdata <= i_req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
                  r_be    <= i_req_be;
`endif
                  r_cnt   <= '0;
                  r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_EXEC;
               end
            end
            S_WAIT: begin
               if (r_cnt == WAIT_LAST) r_state <= S_EXEC;
               else                    r_cnt   <= r_cnt + 4'd1;
            end
            S_EXEC: begin
               r_err   <= w_err;
               r_rdata <= (!r_we && !w_err) ? w_old : '0;
               if (r_we && !w_err) begin
                  r_mem[w_idx] <= w_wword;
                  if (w_idx == '0) r_test_value <= w_wword[15:0];
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (i_resp_ready) begin
                  r_rdata <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready  = (r_state == S_IDLE) & i_reset;
   assign o_resp_valid = (r_state == S_RESP);
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;
   assign o_test_value = r_test_value;

endmodule
